// File: rtl/alu_pkg.sv
// Shared opcode and sequencer state definitions for the alu4bit ALU and the
// command sequencer that drives it.
package alu_pkg;

  localparam int OPCODE_WIDTH = 4;

  localparam logic [OPCODE_WIDTH-1:0] OP_ADD   = 4'd0;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB   = 4'd1;
  localparam logic [OPCODE_WIDTH-1:0] OP_NOTA  = 4'd2;
  localparam logic [OPCODE_WIDTH-1:0] OP_AND   = 4'd3;
  localparam logic [OPCODE_WIDTH-1:0] OP_OR    = 4'd4;
  localparam logic [OPCODE_WIDTH-1:0] OP_NAND  = 4'd5;
  localparam logic [OPCODE_WIDTH-1:0] OP_NOR   = 4'd6;
  localparam logic [OPCODE_WIDTH-1:0] OP_XOR   = 4'd7;
  localparam logic [OPCODE_WIDTH-1:0] OP_XNOR  = 4'd8;
  localparam logic [OPCODE_WIDTH-1:0] OP_PASSA = 4'd9;
  localparam logic [OPCODE_WIDTH-1:0] OP_ZERO  = 4'd10;
  localparam logic [OPCODE_WIDTH-1:0] OP_ONE   = 4'd11;
  localparam logic [OPCODE_WIDTH-1:0] OP_INCA  = 4'd12;
  localparam logic [OPCODE_WIDTH-1:0] OP_DECA  = 4'd13;
  localparam logic [OPCODE_WIDTH-1:0] OP_INCB  = 4'd14;
  localparam logic [OPCODE_WIDTH-1:0] OP_DECB  = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu4bit.sv
// Combinational 4-bit ALU; all 16 opcodes defined, wrap-around arithmetic,
// no carry or overflow output.
module alu4bit
  import alu_pkg::*;
(
  input  logic [3:0]              a,
  input  logic [3:0]              b,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  output logic [3:0]              y
);

  always_comb begin
    y = '0;
    case (opcode)
      OP_ADD:   y = a + b;
      OP_SUB:   y = a - b;
      OP_NOTA:  y = ~a;
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_NAND:  y = ~(a & b);
      OP_NOR:   y = ~(a | b);
      OP_XOR:   y = a ^ b;
      OP_XNOR:  y = ~(a ^ b);
      OP_PASSA: y = a;
      OP_ZERO:  y = 4'd0;
      OP_ONE:   y = 4'd1;
      OP_INCA:  y = a + 4'd1;
      OP_DECA:  y = a - 4'd1;
      OP_INCB:  y = b + 4'd1;
      OP_DECB:  y = b - 4'd1;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Accumulator-style command sequencer for an external combinational ALU:
// accept command, hold ALU inputs for one cycle, write back and return result.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [OPCODE_WIDTH-1:0] cmd_op,
  input  logic [WIDTH-1:0]        cmd_operand,
  input  logic                    cmd_load,
  output logic [WIDTH-1:0]        alu_a,
  output logic [WIDTH-1:0]        alu_b,
  output logic [OPCODE_WIDTH-1:0] alu_opcode,
  input  logic [WIDTH-1:0]        alu_y,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [WIDTH-1:0]        res_data,
  output logic                    res_zero,
  output logic [WIDTH-1:0]        acc,
  output logic [CNT_WIDTH-1:0]    op_count
);

  state_t state_reg, state_next;
  logic   load_reg;
  logic   accept;
  logic   exec;
  logic [WIDTH-1:0] result;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    exec       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          accept     = 1'b1;
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        exec       = 1'b1;
        state_next = ST_RESP;
      end
      ST_RESP: begin
        if (res_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Handshake flags are pure state decodes: no path from cmd_valid/res_ready.
  assign cmd_ready = (state_reg == ST_IDLE);
  assign res_valid = (state_reg == ST_RESP);

  // Load commands carry their value through alu_b so the ALU result is ignored.
  assign result = load_reg ? alu_b : alu_y;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      load_reg   <= 1'b0;
      res_data   <= '0;
      res_zero   <= 1'b1;
      op_count   <= '0;
    end else if (accept) begin
      alu_a      <= acc;
      alu_b      <= cmd_operand;
      alu_opcode <= cmd_op;
      load_reg   <= cmd_load;
    end else if (exec) begin
      acc        <= result;
      res_data   <= result;
      res_zero   <= (result == '0);
      op_count   <= op_count + 1'b1;
    end
  end

endmodule
